// File: rtl/ts4231_pulse_capture.sv
// TS4231 envelope pulse capture: timestamps and measures low pulses on E into a FIFO stream.
// Optional 3-sample deglitch filter on the synchronized E line: TS4231_PULSE_DEGLITCH_EN.
module ts4231_pulse_capture #(
    parameter int TS_WIDTH   = 24,
    parameter int MIN_WIDTH  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                e_in,
    output logic                pulse_valid,
    input  logic                pulse_ready,
    output logic [TS_WIDTH-1:0] pulse_timestamp,
    output logic [15:0]         pulse_width,
    output logic                overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = TS_WIDTH + 16;

    typedef enum logic [1:0] {
        ARM,
        IDLE,
        MEASURE
    } state_t;

    logic                s1;
    logic                s2;
    logic                e_line;
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            ts <= '0;
        end else begin
            s1 <= e_in;
            s2 <= s1;
            ts <= ts + TS_WIDTH'(1);
        end
    end

`ifdef TS4231_PULSE_DEGLITCH_EN
    logic h0;
    logic h1;
    logic e_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            h0     <= 1'b1;
            h1     <= 1'b1;
            e_hold <= 1'b1;
        end else begin
            h0     <= s2;
            h1     <= h0;
            e_hold <= e_line;
        end
    end

    // Level only follows s2 once three consecutive samples agree.
    always_comb begin
        e_line = e_hold;
        if ((s2 == h0) && (h0 == h1)) begin
            e_line = s2;
        end
    end
`else
    assign e_line = s2;
`endif

    state_t              state;
    state_t              state_n;
    logic [TS_WIDTH-1:0] ts_lat;
    logic [15:0]         width;
    logic [15:0]         width_n;
    logic                lat_ld;
    logic                push;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ARM;
            ts_lat <= '0;
            width  <= '0;
        end else begin
            state <= state_n;
            width <= width_n;
            if (lat_ld) begin
                ts_lat <= ts;
            end
        end
    end

    always_comb begin
        state_n = state;
        width_n = width;
        lat_ld  = 1'b0;
        push    = 1'b0;
        if (!enable) begin
            state_n = ARM;
        end else begin
            unique case (state)
                ARM: begin
                    if (e_line) begin
                        state_n = IDLE;
                    end
                end
                IDLE: begin
                    if (!e_line) begin
                        state_n = MEASURE;
                        lat_ld  = 1'b1;
                        width_n = 16'd1;
                    end
                end
                MEASURE: begin
                    if (e_line) begin
                        state_n = IDLE;
                        push    = (width >= 16'(MIN_WIDTH))
                               && (width != 16'hFFFF);
                    end else if (width != 16'hFFFF) begin
                        width_n = width + 16'd1;
                    end
                end
                default: state_n = ARM;
            endcase
        end
    end

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [DW-1:0] head;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign wr_data     = {ts_lat, width};
    assign full        = (count == CW'(FIFO_DEPTH));
    assign pulse_valid = (count != '0);
    assign pop         = pulse_valid && pulse_ready;
    assign wr_en       = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // head is a register copy of mem[rd_ptr] so outputs hold once drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            head     <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop && (count > CW'(1))) begin
                head <= mem[rd_ptr + AW'(1)];
            end else if (wr_en && ((count == '0)
                         || (pop && (count == CW'(1))))) begin
                head <= wr_data;
            end
        end
    end

    assign pulse_timestamp = head[DW-1:16];
    assign pulse_width     = head[15:0];

endmodule

// File: tb/tb_ts4231_pulse_capture.sv
// Bench for ts4231_pulse_capture: directed and random pulses vs a pulse-level model.
// Expected latency follows TS4231_PULSE_DEGLITCH_EN when it is defined.
module tb_ts4231_pulse_capture;

    localparam int TSW   = 24;
    localparam int MINW  = 10;
    localparam int DEPTH = 4;
`ifdef TS4231_PULSE_DEGLITCH_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            e_in = 1'b1;
    logic            pulse_ready = 1'b1;
    logic            pulse_valid;
    logic [TSW-1:0]  pulse_timestamp;
    logic [15:0]     pulse_width;
    logic            overflow;

    ts4231_pulse_capture #(
        .TS_WIDTH   (TSW),
        .MIN_WIDTH  (MINW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .e_in            (e_in),
        .pulse_valid     (pulse_valid),
        .pulse_ready     (pulse_ready),
        .pulse_timestamp (pulse_timestamp),
        .pulse_width     (pulse_width),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             e;
        logic [TSW-1:0] ts;
        logic [15:0]    w;
    } ev_t;

    ev_t            pend[$];
    ev_t            mq[$];
    logic [TSW-1:0] tsm = '0;
    int             ecount = 0;
    bit             om = 1'b0;
    bit             rand_ready = 1'b0;
    logic [TSW-1:0] last_ts = '0;
    logic [15:0]    last_w = '0;
    int             tests = 0;
    int             fails = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check outputs before the edge, then advance the reference model.
    task automatic tick();
        bit  popd;
        ev_t x;
        if (rand_ready) pulse_ready = 1'($urandom_range(0, 1));
        chk("valid", 64'(pulse_valid), 64'(mq.size() != 0));
        chk("overflow", 64'(overflow), 64'(om));
        if (mq.size() != 0) begin
            chk("head_ts", 64'(pulse_timestamp), 64'(mq[0].ts));
            chk("head_w", 64'(pulse_width), 64'(mq[0].w));
            if (pulse_ready) begin
                last_ts = mq[0].ts;
                last_w  = mq[0].w;
            end
        end else begin
            chk("hold_ts", 64'(pulse_timestamp), 64'(last_ts));
            chk("hold_w", 64'(pulse_width), 64'(last_w));
        end
        @(posedge clk);
        ecount++;
        if (reset) begin
            mq.delete();
            pend.delete();
            om      = 1'b0;
            tsm     = '0;
            last_ts = '0;
            last_w  = '0;
        end else begin
            popd = (mq.size() != 0) && pulse_ready;
            if (popd) void'(mq.pop_front());
            if (pend.size() != 0 && pend[0].e == ecount) begin
                x = pend.pop_front();
                if (mq.size() >= DEPTH) om = 1'b1;
                else mq.push_back(x);
            end
            tsm++;
        end
        #1;
    endtask

    task automatic pulse(int lo, int hi, bit keep);
        logic [TSW-1:0] tf;
        ev_t            x;
        e_in = 1'b0;
        tf   = tsm;
        repeat (lo) tick();
        e_in = 1'b1;
        if (keep && lo >= MINW && lo < 65535) begin
            x.e  = ecount + 1 + LAT;
            x.ts = tf + TSW'(LAT);
            x.w  = 16'(lo);
            pend.push_back(x);
        end
        repeat (hi) tick();
    endtask

    task automatic wait_empty(int budget);
        int n;
        n = 0;
        while ((mq.size() != 0 || pend.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(mq.size() + pend.size()), 64'(0));
    endtask

    initial begin
        logic [TSW-1:0] tf;
        ev_t            x;
        @(posedge clk);
        #1;
        repeat (3) tick();
        chk("rst_valid", 64'(pulse_valid), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_ts", 64'(pulse_timestamp), 64'(0));
        chk("rst_w", 64'(pulse_width), 64'(0));

        reset  = 1'b0;
        enable = 1'b1;
        while (tsm != TSW'(100)) tick();
        pulse_ready = 1'b0;
        pulse(200, 10, 1'b1);
        chk("t1_ts", 64'(pulse_timestamp), 64'(100 + LAT));
        chk("t1_w", 64'(pulse_width), 64'(200));
        pulse_ready = 1'b1;
        wait_empty(20);

        pulse(9, 10, 1'b1);
        pulse(10, 10, 1'b1);
        wait_empty(20);
        chk("runt_ovf", 64'(overflow), 64'(0));

`ifdef TS4231_PULSE_DEGLITCH_EN
        e_in = 1'b0;
        tf   = tsm;
        repeat (49) tick();
        e_in = 1'b1;
        repeat (2) tick();
        e_in = 1'b0;
        repeat (49) tick();
        e_in = 1'b1;
        x.e  = ecount + 1 + LAT;
        x.ts = tf + TSW'(LAT);
        x.w  = 16'd100;
        pend.push_back(x);
        repeat (10) tick();
`else
        pulse(49, 2, 1'b1);
        pulse(49, 10, 1'b1);
        pulse(20, 1, 1'b1);
        pulse(20, 10, 1'b1);
`endif
        wait_empty(20);

        rand_ready = 1'b1;
        repeat (40) pulse($urandom_range(3, 80), $urandom_range(3, 20), 1'b1);
        rand_ready  = 1'b0;
        pulse_ready = 1'b1;
        wait_empty(200);

        enable = 1'b0;
        e_in   = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        repeat (30) tick();
        e_in = 1'b1;
        repeat (10) tick();
        pulse(25, 10, 1'b1);
        wait_empty(20);

        e_in = 1'b0;
        repeat (20) tick();
        enable = 1'b0;
        repeat (5) tick();
        e_in = 1'b1;
        repeat (10) tick();
        enable = 1'b1;
        repeat (10) tick();
        pulse(30, 10, 1'b1);
        wait_empty(20);

        pulse(70000, 10, 1'b1);
        pulse(20, 10, 1'b1);
        wait_empty(20);
        chk("sat_w", 64'(pulse_width), 64'(20));

        pulse_ready = 1'b0;
        repeat (5) pulse(50, 10, 1'b1);
        chk("ovf_set", 64'(overflow), 64'(1));
        pulse_ready = 1'b1;
        wait_empty(20);
        chk("ovf_sticky", 64'(overflow), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
